fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
Shares one combinational FP16 adder (fp_add) between NUM_REQ requesters inside a GraphPulse PE, e.g. event-coalescing lanes that accumulate deltas.
- Round-robin arbitration with valid/ready handshakes on both sides.
- Operand and result stages are registered, giving a 2-stage pipeline around fp_add.
- Each result returns with the winning requester's index and a pass-through tag.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), width of requester index
TAG_W, 8, opaque per-request tag carried alongside operands

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_opA  in  NUM_REQ*16  packed FP16 operand A, requester i at [16i+:16]
req_opB  in  NUM_REQ*16  packed FP16 operand B
req_tag  in  NUM_REQ*TAG_W  packed tags
req_ready  out  NUM_REQ  one-hot; request i accepted this cycle when req_valid[i]&&req_ready[i]
out_valid  out  1  result valid
out_sum  out  16  FP16 sum from fp_add
out_id  out  ID_W  index of requester that issued the op
out_tag  out  TAG_W  tag of that op
out_ready  in  1  downstream accepts result
busy  out  1  s1_valid|s2_valid

Behaviour:
- Reset (async assert, sync-deassert-safe):
  - s1_valid=0, s2_valid=0, rr_ptr=0.
  - All outputs are 0: out_valid, out_sum, out_id, out_tag, busy, req_ready.
  - Assertion mid-operation flushes both stages and discards in-flight ops; no result is emitted for them.
- Stage S2 (output):
  - s2_adv = s2_valid && out_ready.
  - s2_free = !s2_valid || out_ready.
  - out_* are driven directly from S2 registers.
  - out_sum/out_id/out_tag hold stable while out_valid && !out_ready.
- Stage S1 (operands):
  - Registers opA, opB, id, tag.
  - fp_add is fed from S1 registers.
  - On s1_valid && s2_free: S2 loads {fp_add.sum, id, tag} and s2_valid=1.
  - Otherwise s2_valid clears only if s2_adv.
- Accept condition: accept = !s1_valid || s2_free (S1 empties or moves this cycle).
- Arbitration:
  - Combinational round-robin over req_valid, starting search at rr_ptr, wrapping NUM_REQ-1 -> 0.
  - req_ready[g]=1 only for winner g, only when accept=1; all other bits are 0.
  - req_ready is 0 when no request is valid.
  - On handshake: S1 loads the winner's operands/tag, id=g, s1_valid=1, and rr_ptr=(g+1) mod NUM_REQ.
  - With no handshake, rr_ptr holds; if S1 moves without a new load, s1_valid=0.
- Latency and throughput:
  - Request handshake in cycle t -> out_valid in cycle t+2 if unstalled.
  - Throughput is 1 op/cycle with out_ready held high.
- Fairness: a continuously asserted requester is granted within NUM_REQ accepts.
- Requester-side rule: requesters must hold valid/operands until handshake; the block does not check this.
- Backpressure: with out_ready=0 and both stages full, all req_ready=0; no op is dropped or duplicated.
- Simultaneous S2 drain, S1->S2 move and new S1 load in one cycle are legal and required.

Optional Feature:
FP_ADD_ARB_STATS_EN
- Defined: adds outputs stat_ops (32b) and stat_stall (32b).
  - stat_ops increments on every out_valid&&out_ready.
  - stat_stall increments every cycle with out_valid&&!out_ready.
  - Both saturate at all-ones and clear on reset_n=0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single op: req0 opA=22fc, opB=37dc, tag=0x11 -> 2 cycles later out_valid=1, out_sum=380a, out_id=0, out_tag=0x11.
- Back-to-back throughput: req1 sends 39e3+3b38, then 22fc+37dc, with out_ready=1 -> out_sum=3e8e then 380a on consecutive cycles, out_id=1.
- Round-robin: all 4 req_valid held high, out_ready=1 -> grant order 0,1,2,3,0; out_id matches that sequence.
- Backpressure: out_ready=0 for 5 cycles with 3 requests pending -> exactly 2 accepted; outputs stable; req_ready=0 after; all 3 results delivered in order once out_ready=1.
- Reset mid-flight: reset_n low for 1 cycle with both stages full -> out_valid=0, busy=0, rr_ptr=0; next request is granted to lowest valid index.
- Stats (FP_ADD_ARB_STATS_EN): 3 ops plus 4 stall cycles -> stat_ops=3, stat_stall=4.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one combinational FP16 adder between NUM_REQ requesters.
// A round-robin arbiter feeds a registered operand stage (S1). The adder sits
// between S1 and a registered result stage (S2), so a result appears two cycles
// after its request handshake when nothing stalls.
//
// Ports:
//   clock, reset_n             clock (rising edge) / asynchronous active-low reset
//   req_valid[NUM_REQ]         per-requester request valid
//   req_opA/req_opB            packed FP16 operands, requester i at [16i+:16]
//   req_tag                    packed per-request tags, requester i at [TAG_W*i+:TAG_W]
//   req_ready[NUM_REQ]         one-hot grant; request i accepted when valid&ready
//   out_valid/out_ready        result handshake
//   out_sum/out_id/out_tag     FP16 sum, winning requester index, its tag
//   busy                       either pipeline stage holds an op
//   stat_ops/stat_stall        saturating counters, present only with FP_ADD_ARB_STATS_EN
//
// Optional feature macro: FP_ADD_ARB_STATS_EN

module fp_add_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ),
   parameter int unsigned TAG_W   = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*16-1:0]    req_opA,
   input  logic [NUM_REQ*16-1:0]    req_opB,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     out_valid,
   output logic [15:0]              out_sum,
   output logic [ID_W-1:0]          out_id,
   output logic [TAG_W-1:0]         out_tag,
   input  logic                     out_ready,
`ifdef FP_ADD_ARB_STATS_EN
   output logic [31:0]              stat_ops,
   output logic [31:0]              stat_stall,
`endif
   output logic                     busy
);

   localparam int unsigned OP_W = 16;

   // IEEE-754 binary16 addition, round-to-nearest-even, subnormals supported.
   // Significands carry three extra bits (guard, round, sticky) during alignment.
   function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
      logic        a_nan, b_nan, a_inf, b_inf;
      logic [15:0] big, sml, res;
      logic [4:0]  e_big, e_sml, d;
      logic [13:0] m_big, m_sml, m_sh, mask, n;
      logic        sub, up;
      logic [14:0] sum15;
      logic [5:0]  e;
      logic [11:0] mr;
      a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
      b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
      a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
      b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
      // Larger magnitude first so the aligned subtraction never goes negative.
      if (b[14:0] > a[14:0]) begin
         big = b;
         sml = a;
      end else begin
         big = a;
         sml = b;
      end
      e_big = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
      e_sml = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
      m_big = {|big[14:10], big[9:0], 3'b000};
      m_sml = {|sml[14:10], sml[9:0], 3'b000};
      d     = e_big - e_sml;
      mask  = '0;
      if (d >= 5'd14) begin
         m_sh = {13'd0, |m_sml};
      end else begin
         mask = (14'd1 << d) - 14'd1;
         m_sh = (m_sml >> d) | {13'd0, |(m_sml & mask)};
      end
      sub   = big[15] ^ sml[15];
      sum15 = sub ? ({1'b0, m_big} - {1'b0, m_sh}) : ({1'b0, m_big} + {1'b0, m_sh});
      e     = {1'b0, e_big};
      if (sum15[14]) begin
         n = {sum15[14:2], sum15[1] | sum15[0]};
         e = e + 6'd1;
      end else begin
         n = sum15[13:0];
         // Left-normalise, stopping at the subnormal exponent.
         for (int i = 0; i < 13; i++) begin
            if (!n[13] && (e > 6'd1)) begin
               n = n << 1;
               e = e - 6'd1;
            end
         end
      end
      up = n[2] & (n[1] | n[0] | n[3]);
      mr = {1'b0, n[13:3]} + 12'(up);
      if (mr[11]) begin
         mr = mr >> 1;
         e  = e + 6'd1;
      end
      if (mr == 12'd0) begin
         // Exact cancellation gives +0; same-sign zeros keep their sign.
         res = {sub ? 1'b0 : big[15], 15'd0};
      end else if (e >= 6'd31) begin
         res = {big[15], 5'h1f, 10'd0};
      end else begin
         res = {big[15], mr[10] ? e[4:0] : 5'd0, mr[9:0]};
      end
      if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
         res = 16'h7e00;
      end else if (a_inf) begin
         res = a;
      end else if (b_inf) begin
         res = b;
      end
      return res;
   endfunction

   // Unpack the flat request buses.
   logic [OP_W-1:0]  opa_arr [NUM_REQ];
   logic [OP_W-1:0]  opb_arr [NUM_REQ];
   logic [TAG_W-1:0] tag_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign opa_arr[g] = req_opA[g*OP_W +: OP_W];
      assign opb_arr[g] = req_opB[g*OP_W +: OP_W];
      assign tag_arr[g] = req_tag[g*TAG_W +: TAG_W];
   end

   logic              s1_valid_q, s1_valid_d;
   logic [OP_W-1:0]   s1_opa_q, s1_opa_d;
   logic [OP_W-1:0]   s1_opb_q, s1_opb_d;
   logic [ID_W-1:0]   s1_id_q, s1_id_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
   logic              s2_valid_q, s2_valid_d;
   logic [OP_W-1:0]   s2_sum_q, s2_sum_d;
   logic [ID_W-1:0]   s2_id_q, s2_id_d;
   logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              busy_q, busy_d;

   logic              s2_adv, s2_free, s1_move, accept, hs;
   logic              grant_any;
   logic [ID_W-1:0]   grant_idx;
   int unsigned       cand;
   logic [OP_W-1:0]   add_sum;

   assign s2_adv  = s2_valid_q && out_ready;
   assign s2_free = !s2_valid_q || out_ready;
   assign s1_move = s1_valid_q && s2_free;
   assign accept  = !s1_valid_q || s2_free;
   assign hs      = grant_any && accept;
   assign add_sum = fp_add(s1_opa_q, s1_opb_q);

   // Round-robin search starting at rr_ptr_q, first valid requester wins.
   always_comb begin : arbiter
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (32'(rr_ptr_q) + 32'(k)) % NUM_REQ;
         if (!grant_any && req_valid[ID_W'(cand)]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(cand);
         end
      end
   end

   // Grant is masked during reset so nothing looks accepted while flops are held.
   always_comb begin : ready_gen
      req_ready = '0;
      if (hs && reset_n) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Pipeline next state: S2 drain, S1->S2 move and S1 load may all happen together.
   always_comb begin : next_state
      s1_valid_d = s1_valid_q;
      s1_opa_d   = s1_opa_q;
      s1_opb_d   = s1_opb_q;
      s1_id_d    = s1_id_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_sum_d   = s2_sum_q;
      s2_id_d    = s2_id_q;
      s2_tag_d   = s2_tag_q;
      rr_ptr_d   = rr_ptr_q;
      if (s1_move) begin
         s2_valid_d = 1'b1;
         s2_sum_d   = add_sum;
         s2_id_d    = s1_id_q;
         s2_tag_d   = s1_tag_q;
      end else if (s2_adv) begin
         s2_valid_d = 1'b0;
      end
      if (hs) begin
         s1_valid_d = 1'b1;
         s1_opa_d   = opa_arr[grant_idx];
         s1_opb_d   = opb_arr[grant_idx];
         s1_tag_d   = tag_arr[grant_idx];
         s1_id_d    = grant_idx;
         rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end else if (s1_move) begin
         s1_valid_d = 1'b0;
      end
      busy_d = s1_valid_d | s2_valid_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin : regs
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_opa_q   <= '0;
         s1_opb_q   <= '0;
         s1_id_q    <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_id_q    <= '0;
         s2_tag_q   <= '0;
         rr_ptr_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_opa_q   <= s1_opa_d;
         s1_opb_q   <= s1_opb_d;
         s1_id_q    <= s1_id_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_sum_q   <= s2_sum_d;
         s2_id_q    <= s2_id_d;
         s2_tag_q   <= s2_tag_d;
         rr_ptr_q   <= rr_ptr_d;
         busy_q     <= busy_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_sum   = s2_sum_q;
   assign out_id    = s2_id_q;
   assign out_tag   = s2_tag_q;
   assign busy      = busy_q;

`ifdef FP_ADD_ARB_STATS_EN
   logic [31:0] stat_ops_q, stat_stall_q;

   // Saturating result and stall counters.
   always_ff @(posedge clock or negedge reset_n) begin : stats
      if (!reset_n) begin
         stat_ops_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         if (s2_adv && (stat_ops_q != '1)) begin
            stat_ops_q <= stat_ops_q + 32'd1;
         end
         if (s2_valid_q && !out_ready && (stat_stall_q != '1)) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end
      end
   end

   assign stat_ops   = stat_ops_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed self-checking bench for fp_add_arbiter (NUM_REQ=4, TAG_W=8).
module tb_fp_add_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned TAG_W   = 8;

   logic                     clock = 1'b0;
   logic                     reset_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*16-1:0]    req_opA;
   logic [NUM_REQ*16-1:0]    req_opB;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     out_valid;
   logic [15:0]              out_sum;
   logic [ID_W-1:0]          out_id;
   logic [TAG_W-1:0]         out_tag;
   logic                     out_ready;
   logic                     busy;
`ifdef FP_ADD_ARB_STATS_EN
   logic [31:0]              stat_ops;
   logic [31:0]              stat_stall;
`endif

   logic [15:0]      opa [NUM_REQ];
   logic [15:0]      opb [NUM_REQ];
   logic [TAG_W-1:0] tag [NUM_REQ];
   logic [3:0]       hs;

   int n_checks = 0;
   int n_fail   = 0;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign req_opA[g*16 +: 16]       = opa[g];
      assign req_opB[g*16 +: 16]       = opb[g];
      assign req_tag[g*TAG_W +: TAG_W] = tag[g];
   end

   fp_add_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TAG_W(TAG_W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_opA   (req_opA),
      .req_opB   (req_opB),
      .req_tag   (req_tag),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_id    (out_id),
      .out_tag   (out_tag),
      .out_ready (out_ready),
`ifdef FP_ADD_ARB_STATS_EN
      .stat_ops  (stat_ops),
      .stat_stall(stat_stall),
`endif
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] t);
      opa[i] = a;
      opb[i] = b;
      tag[i] = t;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = 4'hf;
      out_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h3c00, 16'h3c00, 8'(i));
      tick();
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_sum !== 16'h0) begin n_fail++; $display("FAIL reset_out_sum got %h want 0000", out_sum); end
      n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_out_id got %0d want 0", out_id); end
      n_checks++; if (out_tag !== 8'h0) begin n_fail++; $display("FAIL reset_out_tag got %h want 00", out_tag); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
`ifdef FP_ADD_ARB_STATS_EN
      n_checks++; if (stat_ops !== 32'd0) begin n_fail++; $display("FAIL reset_stat_ops got %0d want 0", stat_ops); end
      n_checks++; if (stat_stall !== 32'd0) begin n_fail++; $display("FAIL reset_stat_stall got %0d want 0", stat_stall); end
`endif
      req_valid = 4'h0;
      reset_n   = 1'b1;
      tick();
   endtask

   task automatic test_single_op();
      set_req(0, 16'h22fc, 16'h37dc, 8'h11);
      req_valid = 4'b0001;
      out_ready = 1'b1;
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", req_ready); end
      tick();
      req_valid = 4'b0000;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
      n_checks++; if (out_sum !== 16'h380a) begin n_fail++; $display("FAIL single_sum got %h want 380a", out_sum); end
      n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL single_id got %0d want 0", out_id); end
      n_checks++; if (out_tag !== 8'h11) begin n_fail++; $display("FAIL single_tag got %h want 11", out_tag); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_drain_busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      set_req(1, 16'h39e3, 16'h3b38, 8'h21);
      req_valid = 4'b0010;
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_ready0 got %b want 0010", req_ready); end
      tick();
      set_req(1, 16'h22fc, 16'h37dc, 8'h22);
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_ready1 got %b want 0010", req_ready); end
      tick();
      req_valid = 4'b0000;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid0 got %b want 1", out_valid); end
      n_checks++; if (out_sum !== 16'h3e8e) begin n_fail++; $display("FAIL b2b_sum0 got %h want 3e8e", out_sum); end
      n_checks++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL b2b_id0 got %0d want 1", out_id); end
      n_checks++; if (out_tag !== 8'h21) begin n_fail++; $display("FAIL b2b_tag0 got %h want 21", out_tag); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1 got %b want 1", out_valid); end
      n_checks++; if (out_sum !== 16'h380a) begin n_fail++; $display("FAIL b2b_sum1 got %h want 380a", out_sum); end
      n_checks++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL b2b_id1 got %0d want 1", out_id); end
      n_checks++; if (out_tag !== 8'h22) begin n_fail++; $display("FAIL b2b_tag1 got %h want 22", out_tag); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
   endtask

   task automatic test_round_robin();
      logic [15:0] rr_sum [4];
      logic [3:0]  exp_rdy;
      int          j;
      rr_sum = '{16'h4000, 16'h380a, 16'h0000, 16'h4200};
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      set_req(0, 16'h3c00, 16'h3c00, 8'h30);
      set_req(1, 16'h22fc, 16'h37dc, 8'h31);
      set_req(2, 16'h3c00, 16'hbc00, 8'h32);
      set_req(3, 16'h4000, 16'h3c00, 8'h33);
      req_valid = 4'hf;
      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k == 5) req_valid = 4'h0;
         #1;
         exp_rdy = (k < 5) ? 4'(1 << (k % 4)) : 4'b0000;
         n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_rdy); end
         if (k >= 2) begin
            j = (k - 2) % 4;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b want 1", k, out_valid); end
            n_checks++; if (out_id !== 2'(j)) begin n_fail++; $display("FAIL rr_id[%0d] got %0d want %0d", k, out_id, j); end
            n_checks++; if (out_sum !== rr_sum[j]) begin n_fail++; $display("FAIL rr_sum[%0d] got %h want %h", k, out_sum, rr_sum[j]); end
            n_checks++; if (out_tag !== 8'(8'h30 + j)) begin n_fail++; $display("FAIL rr_tag[%0d] got %h want %h", k, out_tag, 8'(8'h30 + j)); end
         end
         tick();
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [3:0]  bp_rdy [9];
      logic        bp_ov  [9];
      logic [15:0] bp_sum [9];
      logic [1:0]  bp_id  [9];
      logic [7:0]  bp_tag [9];
      bp_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      bp_ov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bp_sum = '{16'h0, 16'h0, 16'h3e8e, 16'h3e8e, 16'h3e8e, 16'h3e8e, 16'h3c00, 16'h380a, 16'h0};
      bp_id  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
      bp_tag = '{8'h0, 8'h0, 8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h40, 8'h0};
      set_req(0, 16'h22fc, 16'h37dc, 8'h40);
      set_req(1, 16'h39e3, 16'h3b38, 8'h41);
      set_req(2, 16'h4200, 16'hc000, 8'h42);
      req_valid = 4'b0111;
      for (int c = 0; c < 9; c++) begin
         out_ready = (c >= 5);
         #1;
         n_checks++; if (req_ready !== bp_rdy[c]) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want %b", c, req_ready, bp_rdy[c]); end
         n_checks++; if (out_valid !== bp_ov[c]) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want %b", c, out_valid, bp_ov[c]); end
         if (bp_ov[c]) begin
            n_checks++; if (out_sum !== bp_sum[c]) begin n_fail++; $display("FAIL bp_sum[%0d] got %h want %h", c, out_sum, bp_sum[c]); end
            n_checks++; if (out_id !== bp_id[c]) begin n_fail++; $display("FAIL bp_id[%0d] got %0d want %0d", c, out_id, bp_id[c]); end
            n_checks++; if (out_tag !== bp_tag[c]) begin n_fail++; $display("FAIL bp_tag[%0d] got %h want %h", c, out_tag, bp_tag[c]); end
         end
         hs = req_valid & req_ready;
         tick();
         req_valid = req_valid & ~hs;
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end got %b want 0", busy); end
   endtask

   task automatic test_reset_midflight();
      set_req(1, 16'h3c00, 16'h3c00, 8'h61);
      set_req(2, 16'h39e3, 16'h3b38, 8'h62);
      out_ready = 1'b0;
      req_valid = 4'b0110;
      for (int c = 0; c < 2; c++) begin
         #1;
         hs = req_valid & req_ready;
         tick();
         req_valid = req_valid & ~hs;
      end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_full_busy got %b want 1", busy); end
      reset_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
      n_checks++; if (out_sum !== 16'h0) begin n_fail++; $display("FAIL mid_rst_sum got %h want 0000", out_sum); end
      tick();
      reset_n = 1'b1;
      set_req(1, 16'h3c00, 16'h3c00, 8'h51);
      set_req(3, 16'h4000, 16'h3c00, 8'h53);
      req_valid = 4'b1010;
      out_ready = 1'b1;
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_grant got %b want 0010", req_ready); end
      tick();
      req_valid = 4'b0000;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale got %b want 0", out_valid); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid got %b want 1", out_valid); end
      n_checks++; if (out_sum !== 16'h4000) begin n_fail++; $display("FAIL mid_sum got %h want 4000", out_sum); end
      n_checks++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL mid_id got %0d want 1", out_id); end
      n_checks++; if (out_tag !== 8'h51) begin n_fail++; $display("FAIL mid_tag got %h want 51", out_tag); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_end got %b want 0", busy); end
   endtask

`ifdef FP_ADD_ARB_STATS_EN
   task automatic test_stats();
      int cnt;
      cnt     = 0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n_checks++; if (stat_ops !== 32'd0) begin n_fail++; $display("FAIL stats_clr_ops got %0d want 0", stat_ops); end
      set_req(0, 16'h3c00, 16'h3c00, 8'h70);
      req_valid = 4'b0001;
      for (int c = 0; c < 9; c++) begin
         out_ready = (c >= 6);
         #1;
         hs = req_valid & req_ready;
         tick();
         if (hs[0]) begin
            cnt++;
            set_req(0, 16'h3c00, 16'h3c00, 8'(8'h70 + cnt));
         end
         if (cnt == 3) req_valid = 4'b0000;
      end
      n_checks++; if (stat_ops !== 32'd3) begin n_fail++; $display("FAIL stats_ops got %0d want 3", stat_ops); end
      n_checks++; if (stat_stall !== 32'd4) begin n_fail++; $display("FAIL stats_stall got %0d want 4", stat_stall); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stats_drain got %b want 0", out_valid); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_op();
      test_back_to_back();
      test_round_robin();
      test_backpressure();
      test_reset_midflight();
`ifdef FP_ADD_ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
